rr_req_arbiter: RTL and testbench
=================================

Name: rr_req_arbiter

Overview:
- Round-robin arbiter that shares one single-user resource between REQ_CNT requesters.
- The resource is a downstream datapath such as the outer-bit finder.
- Each cycle in IDLE it picks the first set request bit at or above a rotating priority pointer, wrapping around.
- It holds the grant until the owner signals done, drops its request, or exceeds a hold limit. It then advances the pointer past the served requester.

Parameters:
- REQ_CNT, 4: number of requesters. Must be at least 2.
- MAX_HOLD, 16: maximum number of consecutive grant cycles. 0 means unlimited.
- IDX_W, $clog2(REQ_CNT): width of the grant index (derived).
- HOLD_W, $clog2(MAX_HOLD+1): width of the hold counter (derived).

Ports:
- clk_i, input, 1: clock. All state changes on the rising edge.
- rst_ni, input, 1: reset. Asynchronous, active-low.
- req_i, input, REQ_CNT: request vector. Bit k is requester k. Level-sensitive.
- done_i, input, 1: the current owner finished. Meaningful only while grant_val_o=1.
- grant_o, output, REQ_CNT: one-hot grant, registered. All zeros when no grant.
- grant_idx_o, output, IDX_W: binary index of the granted requester. Holds its last value when grant_val_o=0.
- grant_val_o, output, 1: a grant is active (OR of grant_o).
- timeout_o, output, 1: one-cycle pulse when a grant was force-released by the MAX_HOLD limit.

Behaviour:
- Reset (rst_ni=0, asynchronous): state=IDLE, grant_o=0, grant_idx_o=0, grant_val_o=0, timeout_o=0, ptr=0, hold_cnt=0.
- Reset mid-grant drops the grant immediately, with no clock edge required.
- State IDLE:
  - If req_i=0: stay in IDLE, outputs 0.
  - Otherwise select sel = the first k in the order ptr, ptr+1, …, REQ_CNT-1, 0, …, ptr-1 with req_i[k]=1.
  - On the next edge: grant_o=1<<sel, grant_idx_o=sel, grant_val_o=1, hold_cnt=1, state=GRANT.
  - Latency from req_i to grant_o is exactly 1 cycle.
- State GRANT, on each edge, checked in this priority order:
  - (a) done_i=1, or req_i[grant_idx_o]=0: release, timeout_o=0.
  - (b) MAX_HOLD≠0 and hold_cnt==MAX_HOLD: release, timeout_o=1 for exactly one cycle.
  - (c) otherwise: keep the grant and increment hold_cnt, saturating at MAX_HOLD.
- Release:
  - On the next edge grant_o=0, grant_val_o=0, and state=IDLE.
  - ptr = (grant_idx_o+1) mod REQ_CNT. Wrap from REQ_CNT-1 to 0.
  - One mandatory idle (bubble) cycle follows every grant. The next grant can appear no earlier than 2 cycles after the release decision.
- A grant therefore lasts at most MAX_HOLD cycles with grant_val_o=1.
- Requests from non-owners during GRANT are ignored. Request changes are observed only in IDLE.
- done_i in IDLE is ignored.
- done_i on the same edge as the timeout condition: done wins, timeout_o=0.
- A requester that keeps requesting after release is served again only after every other active requester in ring order.
- With a single active requester, it is re-granted after the bubble: grant, 1 idle cycle, grant, and so on.
- timeout_o is asserted in the bubble cycle. It is 0 in all other cycles.
- Invariants:
  - grant_o is always zero or one-hot.
  - grant_val_o == |grant_o.
  - If grant_val_o=1 then grant_o == 1<<grant_idx_o.
- Implementation: registered outputs only, no combinational path from inputs to outputs. The priority search uses the double-width rotate/mask method or an equivalent rotate plus find-first-one over REQ_CNT bits.

Test Plan:
1. Reset, then req_i=4'b0000 for 5 cycles → grant_o=0, grant_val_o=0, timeout_o=0 throughout. Assert rst_ni=0 during an active grant → grant_o=0 immediately, before the next edge.
2. ptr=0, req_i=4'b1010 held, done_i pulsed on the 3rd grant cycle → sequence: grant idx 1 (3 cycles), bubble, grant idx 3, done, bubble, grant idx 1. The full ring order 1→3→1 is verified.
3. req_i=4'b1111 held, done_i pulsed each grant's 1st cycle → grants rotate 0,1,2,3,0, each 1 cycle long, with one bubble between. Wrap 3→0 checked.
4. MAX_HOLD=16, req_i=4'b0100 held, done_i=0 → grant idx 2 for exactly 16 cycles. timeout_o=1 in the following bubble cycle. Re-grant of idx 2 occurs one cycle later.
5. Owner idx 0 drops req_i[0] mid-grant while req_i[2]=1 → grant released, timeout_o=0, ptr=1, next grant idx 2 after the bubble.
6. done_i=1 on the cycle where hold_cnt==MAX_HOLD → release with timeout_o=0. Randomized run of 10000 cycles with checkers for the one-hot invariant, 1-cycle grant latency, MAX_HOLD bound, and no starvation (every asserted request is granted within REQ_CNT·(MAX_HOLD+1) cycles).

Source files
------------

// File: rtl/rr_req_arbiter.sv
// rr_req_arbiter: round-robin arbiter sharing one resource among REQ_CNT
// requesters, with a hold limit and a mandatory idle cycle after each grant.
// Ports:
//   clk_i, rst_ni     clock, async active-low reset
//   req_i[REQ_CNT]    level-sensitive request vector
//   done_i            current owner finished (used only while granted)
//   grant_o[REQ_CNT]  registered one-hot grant
//   grant_idx_o       binary index of the owner (held while idle)
//   grant_val_o       a grant is active
//   timeout_o         one-cycle pulse after a hold-limit release
module rr_req_arbiter #(
    parameter int REQ_CNT  = 4,
    parameter int MAX_HOLD = 16,
    localparam int IDX_W   = $clog2(REQ_CNT),
    localparam int HOLD_W  = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [REQ_CNT-1:0] req_i,
    input  logic               done_i,
    output logic [REQ_CNT-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic               grant_val_o,
    output logic               timeout_o
);

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    state_t             state_q, state_d;
    logic [REQ_CNT-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               to_q, to_d;

    logic [2*REQ_CNT-1:0] dbl;
    logic [REQ_CNT-1:0]   rot;
    logic [IDX_W-1:0]     off;
    logic [IDX_W:0]       sum;
    logic [IDX_W-1:0]     sel;
    logic [IDX_W-1:0]     nxt_ptr;

    // Rotate the request vector so the pointer lands on bit 0, take the
    // lowest set bit, then rotate the offset back into ring coordinates.
    always_comb begin
        dbl = {req_i, req_i} >> ptr_q;
        rot = dbl[REQ_CNT-1:0];
        off = '0;
        for (int i = REQ_CNT - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IDX_W'(i);
            end
        end
        sum = {1'b0, ptr_q} + {1'b0, off};
        if (sum >= (IDX_W + 1)'(REQ_CNT)) begin
            sum = sum - (IDX_W + 1)'(REQ_CNT);
        end
        sel = sum[IDX_W-1:0];
    end

    // Pointer moves just past the owner being released.
    always_comb begin
        if (idx_q == IDX_W'(REQ_CNT - 1)) begin
            nxt_ptr = '0;
        end else begin
            nxt_ptr = idx_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        to_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (|req_i) begin
                    state_d      = ST_GRANT;
                    grant_d      = '0;
                    grant_d[sel] = 1'b1;
                    idx_d        = sel;
                    hold_d       = HOLD_W'(1);
                end
            end
            ST_GRANT: begin
                // done and a dropped request take precedence over the limit
                if (done_i || !req_i[idx_q]) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    ptr_d   = nxt_ptr;
                    hold_d  = '0;
                end else if (MAX_HOLD != 0 &&
                             hold_q == HOLD_W'(MAX_HOLD)) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    ptr_d   = nxt_ptr;
                    hold_d  = '0;
                    to_d    = 1'b1;
                end else if (MAX_HOLD != 0) begin
                    // below the limit here, so no saturation check needed
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            to_q    <= to_d;
        end
    end

    assign grant_o     = grant_q;
    assign grant_idx_o = idx_q;
    assign grant_val_o = |grant_q;
    assign timeout_o   = to_q;

endmodule

// File: tb/tb_rr_req_arbiter.sv
// tb_rr_req_arbiter: directed vectors feed an expected-output queue that a
// monitor drains each cycle, plus a random phase with property checks.
module tb_rr_req_arbiter;

    localparam int N      = 4;
    localparam int MH     = 16;
    localparam int STARVE = N * (MH + 1);

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req   = 4'b0000;
    logic       done  = 1'b0;
    logic       fin   = 1'b0;
    logic [3:0] grant;
    logic [1:0] gidx;
    logic       gval;
    logic       tout;

    always #5 clk = ~clk;

    rr_req_arbiter #(
        .REQ_CNT  (N),
        .MAX_HOLD (MH)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req),
        .done_i      (done),
        .grant_o     (grant),
        .grant_idx_o (gidx),
        .grant_val_o (gval),
        .timeout_o   (tout)
    );

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] i;
        logic       ci;
        logic       t;
    } exp_t;

    exp_t q[$];
    int   errs   = 0;
    int   checks = 0;

    task automatic chk(input string nm, input int a, input int e);
        checks++;
        if (a != e) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, a, e, $time);
        end
    endtask

    task automatic push(input logic [3:0] g, input logic [1:0] i,
                        input logic ci, input logic t);
        exp_t e;
        e.g  = g;
        e.i  = i;
        e.ci = ci;
        e.t  = t;
        q.push_back(e);
    endtask

    // Inputs for this cycle, and the outputs expected in this same cycle.
    task automatic cyc(input logic [3:0] r, input logic d,
                       input logic v, input logic [1:0] i,
                       input logic t);
        logic [3:0] one;
        one  = 4'b0001;
        req  = r;
        done = d;
        push(v ? (one << i) : 4'b0000, i, v, t);
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t       e;
        int         run;
        int         prun;
        int         worst;
        int         wt[N];
        logic       pv;
        logic       pok;
        logic       pdone;
        logic [3:0] preq;
        logic [1:0] pidx;
        run  = 0;
        pv   = 1'b0;
        pok  = 1'b0;
        pdone = 1'b0;
        preq = '0;
        pidx = '0;
        for (int k = 0; k < N; k++) wt[k] = 0;
        forever begin
            @(negedge clk or negedge rst_n);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("grant", int'(grant), int'(e.g));
                chk("timeout", int'(tout), int'(e.t));
                if (e.ci) chk("idx", int'(gidx), int'(e.i));
            end
            chk("val_or", int'(gval), int'(|grant));
            chk("onehot", int'($countones(grant) <= 1), 1);
            if (gval) begin
                chk("idx_match", int'(grant), int'(4'b0001 << gidx));
            end
            if (!rst_n) begin
                pok = 1'b0;
                run = 0;
                for (int k = 0; k < N; k++) wt[k] = 0;
            end else begin
                if (pok && !pv && preq != 4'b0000) begin
                    chk("latency",
                        int'(gval && ((grant & preq) != 4'b0000)), 1);
                end
                if (pok && pv && gval) begin
                    chk("bubble", int'(gidx), int'(pidx));
                end
                prun = run;
                if (gval) run = (pok && pv) ? run + 1 : 1;
                else run = 0;
                chk("hold_bound", int'(run <= MH), 1);
                if (tout) begin
                    chk("to_cause", int'(pok && pv && !gval &&
                        prun == MH && !pdone && preq[pidx]), 1);
                end
                worst = 0;
                for (int k = 0; k < N; k++) begin
                    if (req[k] && !grant[k]) wt[k]++;
                    else wt[k] = 0;
                    if (wt[k] > worst) worst = wt[k];
                end
                chk("starve", int'(worst <= STARVE), 1);
                pok = 1'b1;
            end
            pv    = gval;
            pidx  = gidx;
            preq  = req;
            pdone = done;
            if (fin) begin
                chk("queue_empty", q.size(), 0);
                $display("Result: errors=%0d of %0d checks", errs, checks);
                $finish;
            end
        end
    end

    initial begin
        logic [3:0] r;
        repeat (2) @(posedge clk);
        #1;
        // held in reset: all outputs zero, index zero
        push(4'b0000, 2'd0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        push(4'b0000, 2'd0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // no requests
        repeat (5) cyc(4'b0000, 0, 0, 0, 0);
        // ring 1 -> 3 -> 1 with done on third grant cycle
        cyc(4'b1010, 0, 0, 0, 0);
        cyc(4'b1010, 0, 1, 1, 0);
        cyc(4'b1010, 0, 1, 1, 0);
        cyc(4'b1010, 1, 1, 1, 0);
        cyc(4'b1010, 0, 0, 0, 0);
        cyc(4'b1010, 1, 1, 3, 0);
        cyc(4'b1010, 0, 0, 0, 0);
        cyc(4'b1010, 1, 1, 1, 0);
        cyc(4'b0000, 0, 0, 0, 0);
        cyc(4'b0000, 0, 0, 0, 0);
        // ptr=2: request 0 wraps, then reset mid-grant
        cyc(4'b0001, 0, 0, 0, 0);
        req  = 4'b0001;
        done = 1'b0;
        push(4'b0001, 2'd0, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        push(4'b0000, 2'd0, 1'b1, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        push(4'b0000, 2'd0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // full rotation 0,1,2,3,0 with one-cycle grants
        cyc(4'b1111, 0, 0, 0, 0);
        cyc(4'b1111, 1, 1, 0, 0);
        cyc(4'b1111, 0, 0, 0, 0);
        cyc(4'b1111, 1, 1, 1, 0);
        cyc(4'b1111, 0, 0, 0, 0);
        cyc(4'b1111, 1, 1, 2, 0);
        cyc(4'b1111, 0, 0, 0, 0);
        cyc(4'b1111, 1, 1, 3, 0);
        cyc(4'b1111, 0, 0, 0, 0);
        cyc(4'b1111, 1, 1, 0, 0);
        cyc(4'b0000, 0, 0, 0, 0);
        // hold limit: 16 grant cycles, timeout in bubble, re-grant
        cyc(4'b0100, 0, 0, 0, 0);
        repeat (MH) cyc(4'b0100, 0, 1, 2, 0);
        cyc(4'b0100, 0, 0, 0, 1);
        cyc(4'b0100, 1, 1, 2, 0);
        cyc(4'b0000, 0, 0, 0, 0);
        // owner 0 drops its request, requester 2 follows
        cyc(4'b0101, 0, 0, 0, 0);
        cyc(4'b0101, 0, 1, 0, 0);
        cyc(4'b0100, 0, 1, 0, 0);
        cyc(4'b0100, 0, 0, 0, 0);
        cyc(4'b0100, 1, 1, 2, 0);
        cyc(4'b0000, 0, 0, 0, 0);
        // done coincides with the hold limit: no timeout
        cyc(4'b1000, 0, 0, 0, 0);
        repeat (MH - 1) cyc(4'b1000, 0, 1, 3, 0);
        cyc(4'b1000, 1, 1, 3, 0);
        cyc(4'b0000, 0, 0, 0, 0);
        cyc(4'b0000, 0, 0, 0, 0);
        // random traffic, checked by the monitor's properties
        r = 4'b0000;
        for (int n = 0; n < 10000; n++) begin
            for (int b = 0; b < N; b++) begin
                if (r[b]) begin
                    if ($urandom_range(0, 15) == 0) r[b] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    r[b] = 1'b1;
                end
            end
            req  = r;
            done = ($urandom_range(0, 7) == 0);
            @(posedge clk);
            #1;
        end
        req  = 4'b0000;
        done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        fin = 1'b1;
    end

endmodule
